regfile_op_sequencer: RTL and testbench
=======================================

Name: regfile_op_sequencer

Overview:
Upstream controller for the 8x32 single-port register file, which has `din`, `sel`, load-enable `LE` and output-enable `OE`, all sampled on the rising clock edge. It accepts one command at a time on a valid/ready handshake. For each command it reads up to two operands serially through the file's single read port, computes a 32-bit ALU result, and writes it back. It then reports completion with the result and flags.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 3, register index width (2**ADDR_W registers)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept command
cmd_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 LI, 7 RD
cmd_rd  input  ADDR_W  destination register
cmd_rs1  input  ADDR_W  source A
cmd_rs2  input  ADDR_W  source B
cmd_imm  input  DATA_W  immediate for LI
rf_din  output  DATA_W  to register file din
rf_sel  output  ADDR_W  to register file sel
rf_le  output  1  to register file LE
rf_oe  output  1  to register file OE
rf_out  input  DATA_W  from register file out (registered, valid the cycle after an OE edge)
done  output  1  one-cycle completion pulse
result  output  DATA_W  last result, held until next done
zero  output  1  result == 0, updated with done
carry  output  1  ADD carry-out / SUB borrow (a<b unsigned); 0 for other ops

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; latched command cleared.
  - done, result, zero, carry = 0; cmd_ready=0 while rst_n=0.
  - rf_le=rf_oe=0, rf_sel=0, rf_din=0.
- Mid-operation reset: operation abandoned. No rf_le pulse and no done follows.
- Handshake:
  - cmd_ready = (state==IDLE) & rst_n.
  - A command is accepted when cmd_valid & cmd_ready at posedge, and all cmd_* fields are latched then.
  - cmd_valid while busy is ignored; no queueing.
- rf_* outputs are a combinational decode of state and the latched command. In IDLE: le=0, oe=0, sel=0, din=0.
- States and per-cycle drive:
  - IDLE: wait for accept. Opcode 6 -> WB; otherwise -> RD_A.
  - RD_A: sel=rs1, oe=1, le=0 -> RD_B.
  - RD_B: sel=rs2, oe=1, le=0; op_a <= rf_out at edge (R[rs1]) -> EXEC.
  - EXEC: oe=0, le=0. At the edge, res <= f(op_a, rf_out) using rf_out (=R[rs2]) directly. Opcode 7 -> IDLE with done; else -> WB.
  - WB: sel=rd, le=1, oe=0, din=res (LI: din=imm) -> IDLE with done.
- ALU (modulo 2**DATA_W):
  - ADD: a+b, carry=bit DATA_W.
  - SUB: a-b, carry=(a<b).
  - AND, OR, XOR: bitwise.
  - MOV: a (rs2 read but ignored).
  - LI: imm.
  - RD: a, with no write-back.
- done: registered, high exactly one cycle, the cycle the FSM re-enters IDLE. result, zero and carry update on the same edge; cmd_ready is also 1 that cycle.
- Latency, from accept edge to done-high cycle start: 5 edges for ALU/MOV, 4 for RD, 2 for LI.
- Back-to-back: a command may be accepted in the done cycle. Its reads occur after the prior WB edge, so it sees the updated register.
- rd equal to rs1 or rs2 is legal: reads complete before the write.
- rf_le and rf_oe are never high simultaneously.

Test Plan:
- Reset: hold rst_n=0 3 cycles with cmd_valid=1 -> cmd_ready=0, done=0, rf_le=rf_oe=0. Release -> cmd_ready=1 next cycle, no command accepted during reset.
- LI then RD: LI R0=32'hACA6ACA6 -> rf_le=1, sel=0, din=32'hACA6ACA6 one cycle, done 2 edges after accept. Then RD R0 -> result=32'hACA6ACA6, zero=0, no rf_le pulse.
- ADD with carry: LI R1=32'hFFFFFFFF, LI R2=32'h00000002, ADD R3=R1+R2 -> result=32'h00000001, carry=1, R3 written. RD R3 returns 1.
- SUB borrow/zero:
  - R4=5, R5=5, SUB R6=R4-R5 -> result=0, zero=1, carry=0.
  - SUB R6=R2-R4 (2-5) -> result=32'hFFFFFFFD, carry=1.
- Aliasing plus back-to-back:
  - ADD R1=R1+R1 with R1=3 -> 6.
  - Next command issued in the done cycle, RD R1 -> 6.
  - cmd_valid held high while busy -> exactly one accept per command.
- Reset mid-op: assert rst_n=0 during EXEC of ADD R7=R1+R2 -> no rf_le cycle and no done. RD R7 afterwards returns its prior value.

Source files
------------

// File: rtl/regfile_op_sequencer_if.sv
// Bundle of every non-clock/reset signal of regfile_op_sequencer.
//   Command channel : cmd_valid/cmd_ready handshake plus cmd_op, cmd_rd,
//                     cmd_rs1, cmd_rs2, cmd_imm.
//   Completion      : done pulse with result, zero, carry.
//   Register file   : rf_din, rf_sel, rf_le, rf_oe towards the file,
//                     rf_out back from it.
// Modports:
//   slave  - the sequencer itself.
//   master - its environment (command issuer together with the register
//            file, which supplies rf_out).
interface regfile_op_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;

  logic [DATA_W-1:0] rf_din;
  logic [ADDR_W-1:0] rf_sel;
  logic              rf_le;
  logic              rf_oe;
  logic [DATA_W-1:0] rf_out;

  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              carry;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rf_out,
    output cmd_ready, rf_din, rf_sel, rf_le, rf_oe, done, result, zero, carry
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rf_out,
    input  cmd_ready, rf_din, rf_sel, rf_le, rf_oe, done, result, zero, carry
  );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Command sequencer in front of a single-port register file.
// Accepts one command at a time, reads up to two operands serially through
// the file's read port, computes an ALU result and writes it back, then
// pulses done with result/zero/carry.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - regfile_op_sequencer_if.slave (command, completion, rf_* signals)
// Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 LI, 7 RD.
module regfile_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  regfile_op_sequencer_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LI  = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Latched command
  logic [2:0]        op_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [ADDR_W-1:0] rs1_reg;
  logic [ADDR_W-1:0] rs2_reg;
  logic [DATA_W-1:0] imm_reg;

  // Datapath
  logic [DATA_W-1:0] op_a_reg;
  logic [DATA_W-1:0] res_reg;
  logic              res_carry_reg;

  // Completion outputs
  logic              done_reg;
  logic [DATA_W-1:0] result_reg;
  logic              zero_reg;
  logic              carry_reg;

  // FSM combinational outputs
  logic              accept;
  logic              done_set;
  logic [DATA_W-1:0] fin_val;
  logic              fin_carry;
  logic [ADDR_W-1:0] sel_next;
  logic              le_next;
  logic              oe_next;
  logic [DATA_W-1:0] din_next;

  // ALU
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   alu_sum;

  assign bus.cmd_ready = (state_reg == IDLE) & rst_n;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  // Operand B is taken straight from rf_out in EXEC; it holds R[rs2] then.
  assign alu_sum = {1'b0, op_a_reg} + {1'b0, bus.rf_out};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_reg)
      OP_ADD: begin
        alu_res   = alu_sum[DATA_W-1:0];
        alu_carry = alu_sum[DATA_W];
      end
      OP_SUB: begin
        alu_res   = op_a_reg - bus.rf_out;
        alu_carry = (op_a_reg < bus.rf_out);
      end
      OP_AND:  alu_res = op_a_reg & bus.rf_out;
      OP_OR:   alu_res = op_a_reg | bus.rf_out;
      OP_XOR:  alu_res = op_a_reg ^ bus.rf_out;
      OP_MOV:  alu_res = op_a_reg;
      OP_LI:   alu_res = imm_reg;
      OP_RD:   alu_res = op_a_reg;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = '0;
    le_next    = 1'b0;
    oe_next    = 1'b0;
    din_next   = '0;
    done_set   = 1'b0;
    fin_val    = res_reg;
    fin_carry  = res_carry_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (bus.cmd_op == OP_LI) ? WB : RD_A;
        end
      end
      RD_A: begin
        sel_next   = rs1_reg;
        oe_next    = 1'b1;
        state_next = RD_B;
      end
      RD_B: begin
        sel_next   = rs2_reg;
        oe_next    = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        if (op_reg == OP_RD) begin
          // Read-only command completes here without a write-back cycle.
          state_next = IDLE;
          done_set   = 1'b1;
          fin_val    = op_a_reg;
          fin_carry  = 1'b0;
        end else begin
          state_next = WB;
        end
      end
      WB: begin
        sel_next   = rd_reg;
        le_next    = 1'b1;
        din_next   = (op_reg == OP_LI) ? imm_reg : res_reg;
        state_next = IDLE;
        done_set   = 1'b1;
        fin_val    = din_next;
        // LI skips EXEC, so res_carry_reg may be stale from an older command.
        fin_carry  = (op_reg == OP_LI) ? 1'b0 : res_carry_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      rd_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      imm_reg       <= '0;
      op_a_reg      <= '0;
      res_reg       <= '0;
      res_carry_reg <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      carry_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_set;
      if (accept) begin
        op_reg  <= bus.cmd_op;
        rd_reg  <= bus.cmd_rd;
        rs1_reg <= bus.cmd_rs1;
        rs2_reg <= bus.cmd_rs2;
        imm_reg <= bus.cmd_imm;
      end
      if (state_reg == RD_B) begin
        op_a_reg <= bus.rf_out;
      end
      if (state_reg == EXEC) begin
        res_reg       <= alu_res;
        res_carry_reg <= alu_carry;
      end
      if (done_set) begin
        result_reg <= fin_val;
        zero_reg   <= (fin_val == '0);
        carry_reg  <= fin_carry;
      end
    end
  end

  // Strobes are gated with rst_n so nothing reaches the file while reset is
  // held, even before the state register has been cleared.
  assign bus.rf_sel = sel_next;
  assign bus.rf_din = din_next;
  assign bus.rf_le  = le_next & rst_n;
  assign bus.rf_oe  = oe_next & rst_n;

  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.zero   = zero_reg;
  assign bus.carry  = carry_reg;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 8x32 register
// file (registered read on OE, write on LE) attached to the rf_* signals.
module tb_regfile_op_sequencer;
  localparam int DW = 32;
  localparam int AW = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LI  = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_op_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file model
  logic [DW-1:0] mem [0:7];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0000_1000 + i;
    bus.rf_out = '0;
  end
  always @(posedge clk) begin
    if (bus.rf_le) mem[bus.rf_sel] <= bus.rf_din;
    if (bus.rf_oe) bus.rf_out <= mem[bus.rf_sel];
  end

  // Event counters sampled at the active edge
  int accept_cnt = 0;
  int le_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && bus.cmd_valid && bus.cmd_ready) accept_cnt++;
    if (bus.rf_le === 1'b1) le_cnt++;
    if (bus.rf_le === 1'b1 && bus.rf_oe === 1'b1) overlap_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int            last_le_seen;
  logic [AW-1:0] last_wb_sel;
  logic [DW-1:0] last_wb_din;

  // Issue one command and wait (bounded) for its done pulse. On return the
  // bench sits #1 after the edge that raised done. With b2b set, the command
  // is presented immediately so it is accepted at the end of the done cycle.
  task automatic do_cmd(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input int exp_lat, input bit hold, input bit b2b);
    int lat;
    int guard;
    if (!b2b) @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_rd    = rd[AW-1:0];
    bus.cmd_rs1   = rs1[AW-1:0];
    bus.cmd_rs2   = rs2[AW-1:0];
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
    lat = 1;
    last_le_seen = 0;
    last_wb_sel = '0;
    last_wb_din = '0;
    forever begin
      if (bus.rf_le === 1'b1) begin
        last_le_seen++;
        last_wb_sel = bus.rf_sel;
        last_wb_din = bus.rf_din;
      end
      if (bus.done === 1'b1 || lat >= 12) break;
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h -> result=%h zero=%b carry=%b lat=%0d",
             op, rd, rs1, rs2, imm, bus.result, bus.zero, bus.carry, lat);
    check_eq("latency", lat, exp_lat);
  endtask

  int acc0;
  int le0;
  int done0;

  initial begin
    // Reset held with a command on offer
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LI;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.cmd_imm   = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", bus.cmd_ready, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_rf_le", bus.rf_le, 0);
    check_eq("rst_rf_oe", bus.rf_oe, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_zero_carry", {bus.zero, bus.carry}, 0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("rel_cmd_ready", bus.cmd_ready, 1);
    repeat (3) @(negedge clk);
    check_eq("rst_no_accept", accept_cnt, 0);
    check_eq("rst_no_write", le_cnt, 0);
    check_eq("rst_no_done", done_cnt, 0);

    // LI then RD
    do_cmd(OP_LI, 0, 0, 0, 32'hACA6_ACA6, 2, 0, 0);
    check_eq("li_le_once", last_le_seen, 1);
    check_eq("li_sel", last_wb_sel, 0);
    check_eq("li_din", last_wb_din, 32'hACA6_ACA6);
    check_eq("li_result", bus.result, 32'hACA6_ACA6);
    check_eq("li_ready_in_done", bus.cmd_ready, 1);
    do_cmd(OP_RD, 0, 0, 0, 0, 4, 0, 0);
    check_eq("rd0_result", bus.result, 32'hACA6_ACA6);
    check_eq("rd0_zero", bus.zero, 0);
    check_eq("rd0_no_le", last_le_seen, 0);

    // ADD with carry
    do_cmd(OP_LI, 1, 0, 0, 32'hFFFF_FFFF, 2, 0, 0);
    do_cmd(OP_LI, 2, 0, 0, 32'h0000_0002, 2, 0, 0);
    do_cmd(OP_ADD, 3, 1, 2, 0, 5, 0, 0);
    check_eq("add_result", bus.result, 32'h0000_0001);
    check_eq("add_carry", bus.carry, 1);
    check_eq("add_zero", bus.zero, 0);
    check_eq("add_wb_sel", last_wb_sel, 3);
    check_eq("add_wb_din", last_wb_din, 32'h0000_0001);
    do_cmd(OP_RD, 0, 3, 0, 0, 4, 0, 0);
    check_eq("rd3_result", bus.result, 32'h0000_0001);
    check_eq("rd3_carry", bus.carry, 0);

    // SUB: equal operands, then borrow
    do_cmd(OP_LI, 4, 0, 0, 32'd5, 2, 0, 0);
    do_cmd(OP_LI, 5, 0, 0, 32'd5, 2, 0, 0);
    do_cmd(OP_SUB, 6, 4, 5, 0, 5, 0, 0);
    check_eq("sub_eq_result", bus.result, 0);
    check_eq("sub_eq_zero", bus.zero, 1);
    check_eq("sub_eq_carry", bus.carry, 0);
    do_cmd(OP_SUB, 6, 2, 4, 0, 5, 0, 0);
    check_eq("sub_borrow_result", bus.result, 32'hFFFF_FFFD);
    check_eq("sub_borrow_carry", bus.carry, 1);
    check_eq("sub_borrow_zero", bus.zero, 0);

    // Aliasing, valid held while busy, back-to-back read
    do_cmd(OP_LI, 1, 0, 0, 32'd3, 2, 0, 0);
    acc0 = accept_cnt;
    do_cmd(OP_ADD, 1, 1, 1, 0, 5, 1, 0);
    check_eq("alias_result", bus.result, 32'd6);
    check_eq("alias_one_accept", accept_cnt - acc0, 1);
    do_cmd(OP_RD, 0, 1, 0, 0, 4, 0, 1);
    check_eq("b2b_rd_result", bus.result, 32'd6);
    check_eq("b2b_accepts", accept_cnt - acc0, 2);

    // Remaining ALU functions
    do_cmd(OP_AND, 3, 0, 4, 0, 5, 0, 0);
    check_eq("and_result", bus.result, 32'h0000_0004);
    check_eq("and_carry", bus.carry, 0);
    do_cmd(OP_OR, 3, 0, 4, 0, 5, 0, 0);
    check_eq("or_result", bus.result, 32'hACA6_ACA7);
    do_cmd(OP_XOR, 5, 0, 1, 0, 5, 0, 0);
    check_eq("xor_result", bus.result, 32'hACA6_ACA0);
    do_cmd(OP_MOV, 6, 0, 7, 0, 5, 0, 0);
    check_eq("mov_result", bus.result, 32'hACA6_ACA6);
    check_eq("mov_carry", bus.carry, 0);

    // Reset during EXEC of ADD R7=R1+R2
    @(negedge clk);
    bus.cmd_op    = OP_ADD;
    bus.cmd_rd    = 3'd7;
    bus.cmd_rs1   = 3'd1;
    bus.cmd_rs2   = 3'd2;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    le0 = le_cnt;
    done0 = done_cnt;
    #1;
    check_eq("midrst_le", bus.rf_le, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midrst_no_write", le_cnt - le0, 0);
    check_eq("midrst_no_done", done_cnt - done0, 0);
    check_eq("midrst_result_cleared", bus.result, 0);
    do_cmd(OP_RD, 0, 7, 0, 0, 4, 0, 0);
    check_eq("r7_unchanged", bus.result, 32'h0000_1007);
    do_cmd(OP_RD, 0, 6, 0, 0, 4, 0, 0);
    check_eq("r6_mov_written", bus.result, 32'hACA6_ACA6);

    check_eq("le_oe_exclusive", overlap_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
